apb4_slave_regs: RTL and testbench
==================================

APB4_SLAVE_REGS -- requirements
Module: apb4_slave_regs

Interface
REQ-001 Parameter ADDR_W, default 32: paddr width.
REQ-002 Parameter DATA_W, default 32: data width; SHALL be 8, 16 or 32.
REQ-003 Parameter NUM_REGS, default 8: register count, 2..64; register 0 is read-only ID.
REQ-004 Parameter WAIT_STATES, default 0: pready-low cycles inserted per access phase, 0..15.
REQ-005 Parameter ID_VALUE, default 32'hA9B0_0001: register 0 contents, truncated to DATA_W.
REQ-006 pclk  in  1  sole clock; all state changes on rising edge.
REQ-007 preset  in  1  synchronous, active-high reset.
REQ-008 paddr  in  ADDR_W  byte address.
REQ-009 psel  in  1  slave select.
REQ-010 penable  in  1  access phase.
REQ-011 pwrite  in  1  1 = write, 0 = read.
REQ-012 pwdata  in  DATA_W  write data.
REQ-013 pstrb  in  DATA_W/8  write byte strobes.
REQ-014 prdata  out  DATA_W  read data; 0 when not (pready & read).
REQ-015 pready  out  1  transfer completion.
REQ-016 pslverr  out  1  error response; valid only with pready.
REQ-017 reg_q  out  NUM_REGS*DATA_W  flat register contents; register i at bits [i*DATA_W +: DATA_W].

Function
REQ-018 FSM states: IDLE, SETUP, ACCESS.
- IDLE->SETUP on psel & !penable.
- SETUP->ACCESS next cycle unconditionally.
- ACCESS->IDLE on completion cycle, or SETUP if psel & !penable in that same cycle.
REQ-019 psel & penable in IDLE (no preceding setup) SHALL be ignored: no pready, no register change.
REQ-020 Wait counter SHALL clear on SETUP entry and increment each ACCESS cycle with pready low.
REQ-021 pready SHALL be 1 only in ACCESS when counter == WAIT_STATES; WAIT_STATES=0 gives ready in first access cycle.
REQ-022 Address, pwrite, pwdata and pstrb SHALL be captured at SETUP and held through ACCESS; input changes during ACCESS are ignored.
REQ-023 Index = captured paddr >> log2(DATA_W/8); misaligned low bits SHALL give an error.
REQ-024 pslverr SHALL assert with pready when:
- index >= NUM_REGS;
- address misaligned;
- write to register 0.
REQ-025 Write commit occurs on the pready cycle without error.
- Byte k of register updates only where pstrb[k]=1.
- pstrb all-zero SHALL complete with no change and no error.
REQ-026 An erroring write SHALL leave all registers unchanged.
REQ-027 Read data on the pready cycle:
- register 0 returns ID_VALUE;
- other registers return current contents;
- erroring reads return 0.
REQ-028 Read-after-write: a read completing after a write commit SHALL return the new value.
REQ-029 reg_q SHALL reflect a write on the cycle after commit.
REQ-030 psel dropped during ACCESS before ready SHALL abort: FSM to IDLE, no commit, no pready.

Reset
REQ-031 While preset=1 at a clock edge:
- FSM -> IDLE;
- counter -> 0;
- registers 1..NUM_REGS-1 -> 0;
- pready, pslverr, prdata -> 0.
REQ-032 Reset mid-transfer SHALL abort with no commit; the first transfer after reset is accepted from its setup phase.

Structure
REQ-033 Package apb4_pkg SHALL hold the FSM state enum, the ID_VALUE default and the strobe-merge function.
REQ-034 One sub-module, apb4_wait_ctr, SHALL implement the wait counter and pready generation; the register array stays in the top.

Verification
REQ-035 WAIT_STATES=0: write 32'hDEAD_BEEF to 0x04 with pstrb=4'hF, then read 0x04 -> pready on first access cycle each; prdata=32'hDEAD_BEEF; pslverr=0.
REQ-036 WAIT_STATES=3: read 0x00 -> pready low 3 access cycles, high on 4th; prdata=32'hA9B0_0001.
REQ-037 Register 2=32'h1122_3344; write 32'hAABB_CCDD with pstrb=4'b0101 -> read returns 32'h11BB_33DD.
REQ-038 Error cases, each -> pslverr=1 with pready and no register change:
- write 0x00;
- read 0x20 with NUM_REGS=8 (read returns prdata=0);
- access 0x06.
REQ-039 Mid-access aborts, each -> no commit; next transfer completes normally:
- preset asserted during ACCESS of write 0x08;
- psel dropped during ACCESS.
REQ-040 Back-to-back: setup of a read to 0x04 in the completion cycle of a write to 0x04 -> read returns the written value.

Source files
------------

// File: rtl/apb4_pkg.sv
// Shared types and helpers for the APB4 register slave: bus FSM states,
// default ID word and the byte-strobe merge used on register writes.
package apb4_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_ACCESS = 2'd2
   } apb_state_e;

   localparam logic [31:0] ID_VALUE_DEFAULT = 32'hA9B0_0001;

   // Wide enough for the largest supported wait-state count (15).
   localparam int unsigned WAIT_CTR_W = 4;

   function automatic logic [31:0] strb_merge(
      input logic [31:0] old_v,
      input logic [31:0] new_v,
      input logic [3:0]  strb
   );
      logic [31:0] res;
      res = old_v;
      for (int k = 0; k < 4; k++) begin
         if (strb[k]) res[8*k +: 8] = new_v[8*k +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/apb4_wait_ctr.sv
// Access-phase wait counter: cleared on entry to SETUP, counts stalled
// ACCESS cycles and raises pready when the count reaches WAIT_STATES.
module apb4_wait_ctr
   import apb4_pkg::*;
#(
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic pclk,
   input  logic preset,
   input  logic clr,
   input  logic in_access,
   input  logic psel,
   output logic pready
);

   localparam logic [WAIT_CTR_W-1:0] WS_TC = WAIT_CTR_W'(WAIT_STATES);

   logic [WAIT_CTR_W-1:0] cnt_q, cnt_d;

   // Qualified by psel so a deselected access never completes, and by
   // preset so nothing commits in a cycle where reset is being applied.
   always_comb begin
      pready = in_access & psel & ~preset & (cnt_q == WS_TC);
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (in_access && !pready) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/apb4_slave_regs.sv
// APB4 slave with a small register file; register 0 is a read-only ID.
//   state     | meaning
//   ST_IDLE   | no transfer; waiting for psel & !penable
//   ST_SETUP  | bus fields captured, wait counter cleared
//   ST_ACCESS | waiting for pready; psel drop aborts
module apb4_slave_regs
   import apb4_pkg::*;
#(
   parameter int unsigned ADDR_W      = 32,
   parameter int unsigned DATA_W      = 32,
   parameter int unsigned NUM_REGS    = 8,
   parameter int unsigned WAIT_STATES = 0,
   parameter logic [31:0] ID_VALUE    = ID_VALUE_DEFAULT
) (
   input  logic                         pclk,
   input  logic                         preset,
   input  logic [ADDR_W-1:0]            paddr,
   input  logic                         psel,
   input  logic                         penable,
   input  logic                         pwrite,
   input  logic [DATA_W-1:0]            pwdata,
   input  logic [DATA_W/8-1:0]          pstrb,
   output logic [DATA_W-1:0]            prdata,
   output logic                         pready,
   output logic                         pslverr,
   output logic [NUM_REGS*DATA_W-1:0]   reg_q
);

   localparam int unsigned       STRB_W    = DATA_W / 8;
   localparam int unsigned       BYTE_LSB  = $clog2(STRB_W);
   localparam logic [DATA_W-1:0] ID_TRUNC  = ID_VALUE[DATA_W-1:0];
   localparam logic [ADDR_W-1:0] LSB_MASK  = ADDR_W'(STRB_W - 1);
   localparam logic [ADDR_W-1:0] REG_LIMIT = ADDR_W'(NUM_REGS);

   apb_state_e          state_q, state_d;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic                pwrite_q, pwrite_d;
   logic [DATA_W-1:0]   pwdata_q, pwdata_d;
   logic [STRB_W-1:0]   pstrb_q, pstrb_d;
   logic [DATA_W-1:0]   regs_q [1:NUM_REGS-1];
   logic [DATA_W-1:0]   regs_d [1:NUM_REGS-1];

   logic                load;
   logic                in_access;
   logic                ready;
   logic                err;
   logic                commit;
   logic [ADDR_W-1:0]   idx;
   logic [DATA_W-1:0]   rd_data;

   apb4_wait_ctr #(
      .WAIT_STATES (WAIT_STATES)
   ) u_wait_ctr (
      .pclk      (pclk),
      .preset    (preset),
      .clr       (load),
      .in_access (in_access),
      .psel      (psel),
      .pready    (ready)
   );

   always_comb begin
      state_d   = state_q;
      load      = 1'b0;
      in_access = (state_q == ST_ACCESS);
      case (state_q)
         ST_IDLE: begin
            if (psel && !penable) begin
               state_d = ST_SETUP;
               load    = 1'b1;
            end
         end
         ST_SETUP: begin
            state_d = ST_ACCESS;
         end
         ST_ACCESS: begin
            if (!psel) begin
               state_d = ST_IDLE;
            end else if (ready) begin
               if (!penable) begin
                  state_d = ST_SETUP;
                  load    = 1'b1;
               end else begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_comb begin
      addr_d   = addr_q;
      pwrite_d = pwrite_q;
      pwdata_d = pwdata_q;
      pstrb_d  = pstrb_q;
      if (load) begin
         addr_d   = paddr;
         pwrite_d = pwrite;
         pwdata_d = pwdata;
         pstrb_d  = pstrb;
      end
   end

   always_comb begin
      idx    = addr_q >> BYTE_LSB;
      err    = ((addr_q & LSB_MASK) != '0) || (idx >= REG_LIMIT) ||
               (pwrite_q && (idx == '0));
      commit = ready & pwrite_q & ~err;
   end

   // Register decode: read mux and strobe-merged write-back share one loop.
   always_comb begin
      regs_d  = regs_q;
      rd_data = '0;
      if (!err && (idx == '0)) rd_data = ID_TRUNC;
      for (int i = 1; i < NUM_REGS; i++) begin
         if (!err && (idx == ADDR_W'(i))) begin
            rd_data = regs_q[i];
            if (commit) begin
               regs_d[i] = DATA_W'(strb_merge(32'(regs_q[i]), 32'(pwdata_q),
                                              4'(pstrb_q)));
            end
         end
      end
   end

   always_comb begin
      pready  = ready;
      pslverr = ready & err;
      prdata  = (ready && !pwrite_q) ? rd_data : '0;
   end

   always_comb begin
      reg_q              = '0;
      reg_q[DATA_W-1:0]  = ID_TRUNC;
      for (int i = 1; i < NUM_REGS; i++) begin
         reg_q[i*DATA_W +: DATA_W] = regs_q[i];
      end
   end

   always_ff @(posedge pclk) begin
      if (preset) begin
         state_q  <= ST_IDLE;
         addr_q   <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
         for (int i = 1; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
      end else begin
         state_q  <= state_d;
         addr_q   <= addr_d;
         pwrite_q <= pwrite_d;
         pwdata_q <= pwdata_d;
         pstrb_q  <= pstrb_d;
         regs_q   <= regs_d;
      end
   end

endmodule

// File: tb/tb_apb4_slave_regs.sv
// Directed bench for apb4_slave_regs: two instances (0 and 3 wait states)
// share the bus except for psel; a scoreboard queue carries expected results.
module tb_apb4_slave_regs;

   localparam logic [31:0] ID = 32'hA9B0_0001;

   logic         pclk = 1'b0;
   logic         preset;
   logic         psel0, psel3, penable, pwrite;
   logic [31:0]  paddr, pwdata;
   logic [3:0]   pstrb;
   logic [31:0]  prdata0, prdata3;
   logic         pready0, pready3, pslverr0, pslverr3;
   logic [255:0] rq0, rq3;

   always #5 pclk = ~pclk;

   apb4_slave_regs #(.WAIT_STATES(0)) dut0 (
      .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel0),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata0), .pready(pready0), .pslverr(pslverr0), .reg_q(rq0)
   );

   apb4_slave_regs #(.WAIT_STATES(3)) dut3 (
      .pclk(pclk), .preset(preset), .paddr(paddr), .psel(psel3),
      .penable(penable), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
      .prdata(prdata3), .pready(pready3), .pslverr(pslverr3), .reg_q(rq3)
   );

   typedef struct {
      string       tag;
      logic [31:0] rdata;
      logic        err;
      int          waits;
   } exp_t;

   exp_t        sb[$];
   logic [31:0] mdl [2][8];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drive a setup phase (caller is just past a rising edge or at a falling
   // edge of a completion cycle), then raise penable and scramble the bus.
   task automatic start(input bit d3, input logic [31:0] addr, input bit wr,
                        input logic [31:0] wd, input logic [3:0] strb,
                        input bit abort, input string tag);
      int   idx;
      bit   err;
      exp_t e;
      idx     = int'(addr >> 2);
      err     = (addr[1:0] != 2'b00) || (addr >= 32'd32) || (wr && idx == 0);
      e.tag   = tag;
      e.err   = err;
      e.waits = d3 ? 4 : 1;
      e.rdata = 32'h0;
      if (!wr && !err) e.rdata = (idx == 0) ? ID : mdl[d3][idx];
      if (wr && !err && !abort) begin
         for (int k = 0; k < 4; k++) begin
            if (strb[k]) mdl[d3][idx][8*k +: 8] = wd[8*k +: 8];
         end
      end
      if (!abort) sb.push_back(e);
      psel0   = !d3;
      psel3   = d3;
      penable = 1'b0;
      paddr   = addr;
      pwrite  = wr;
      pwdata  = wd;
      pstrb   = strb;
      @(posedge pclk); #1;
      penable = 1'b1;
      paddr   = $urandom;
      pwdata  = ~wd;
      pstrb   = ~strb;
      pwrite  = !wr;
   endtask

   task automatic complete(input bit d3, input bit release_bus);
      int   waits = 0;
      bit   got   = 1'b0;
      exp_t e;
      for (int c = 0; c < 64; c++) begin
         @(negedge pclk);
         if ((d3 ? pready3 : pready0) === 1'b1) begin
            got = 1'b1;
            break;
         end
         waits++;
         @(posedge pclk); #1;
      end
      e = sb.pop_front();
      check({e.tag, "_rdy"}, 32'(got), 32'd1);
      if (got) begin
         check({e.tag, "_waits"}, 32'(waits), 32'(e.waits));
         check({e.tag, "_err"}, 32'(d3 ? pslverr3 : pslverr0), 32'(e.err));
         check({e.tag, "_rdata"}, d3 ? prdata3 : prdata0, e.rdata);
      end
      if (release_bus) begin
         @(posedge pclk); #1;
         psel0   = 1'b0;
         psel3   = 1'b0;
         penable = 1'b0;
      end
   endtask

   task automatic chk_regs(input bit d3, input string tag);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("%s_r%0d", tag, i), d3 ? rq3[i*32 +: 32] : rq0[i*32 +: 32],
               (i == 0) ? ID : mdl[d3][i]);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      preset = 1'b1;
      psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
      paddr = '0; pwdata = '0; pstrb = '0;
      for (int d = 0; d < 2; d++) for (int i = 0; i < 8; i++) mdl[d][i] = 32'h0;

      repeat (3) @(posedge pclk);
      @(negedge pclk);
      check("rst_rdy0", 32'(pready0), 32'd0);
      check("rst_err0", 32'(pslverr0), 32'd0);
      check("rst_rdata0", prdata0, 32'h0);
      check("rst_rdy3", 32'(pready3), 32'd0);
      @(posedge pclk); #1;
      preset = 1'b0;
      chk_regs(0, "init0");
      chk_regs(1, "init3");

      // basic write/read, WAIT_STATES=0
      start(0, 32'h04, 1, 32'hDEAD_BEEF, 4'hF, 0, "wr04"); complete(0, 1);
      start(0, 32'h04, 0, 32'h0, 4'h0, 0, "rd04");         complete(0, 1);
      chk_regs(0, "after_wr04");

      // partial strobes
      start(0, 32'h08, 1, 32'h1122_3344, 4'hF, 0, "wr08");       complete(0, 1);
      start(0, 32'h08, 1, 32'hAABB_CCDD, 4'b0101, 0, "wr08_stb"); complete(0, 1);
      start(0, 32'h08, 0, 32'h0, 4'h0, 0, "rd08");                complete(0, 1);
      check("rd08_reg", rq0[2*32 +: 32], 32'h11BB_33DD);

      // error responses
      start(0, 32'h00, 1, 32'h1234_5678, 4'hF, 0, "wr00"); complete(0, 1);
      start(0, 32'h20, 0, 32'h0, 4'h0, 0, "rd20");         complete(0, 1);
      start(0, 32'h20, 1, 32'hFFFF_FFFF, 4'hF, 0, "wr20"); complete(0, 1);
      start(0, 32'h06, 0, 32'h0, 4'h0, 0, "rd06");         complete(0, 1);
      start(0, 32'h06, 1, 32'hFFFF_FFFF, 4'hF, 0, "wr06"); complete(0, 1);
      chk_regs(0, "after_err");

      // all-zero strobe: completes cleanly, no change
      start(0, 32'h0C, 1, 32'hFFFF_FFFF, 4'h0, 0, "wr0c_nostb"); complete(0, 1);
      chk_regs(0, "after_nostb");

      // psel & penable without setup is ignored
      psel0 = 1'b1; penable = 1'b1; pwrite = 1'b1;
      paddr = 32'h0C; pwdata = 32'h5555_5555; pstrb = 4'hF;
      for (int c = 0; c < 3; c++) begin
         @(negedge pclk);
         check($sformatf("idle_ign_rdy%0d", c), 32'(pready0), 32'd0);
         @(posedge pclk); #1;
      end
      psel0 = 1'b0; penable = 1'b0;
      chk_regs(0, "after_idle_ign");

      // back-to-back: read setup in write completion cycle
      start(0, 32'h04, 1, 32'h5A5A_1234, 4'hF, 0, "b2b_wr"); complete(0, 0);
      start(0, 32'h04, 0, 32'h0, 4'h0, 0, "b2b_rd");         complete(0, 1);

      // reset during ACCESS of a write to 0x08
      start(0, 32'h08, 1, 32'hCAFE_F00D, 4'hF, 1, "rst_wr");
      @(posedge pclk); #1;
      preset = 1'b1;
      @(negedge pclk);
      check("rst_abort_rdy", 32'(pready0), 32'd0);
      check("rst_abort_err", 32'(pslverr0), 32'd0);
      @(posedge pclk); #1;
      preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
      for (int d = 0; d < 2; d++) for (int i = 1; i < 8; i++) mdl[d][i] = 32'h0;
      chk_regs(0, "after_rst");
      start(0, 32'h08, 1, 32'h0BAD_CAFE, 4'hF, 0, "post_rst_wr"); complete(0, 1);
      start(0, 32'h08, 0, 32'h0, 4'h0, 0, "post_rst_rd");         complete(0, 1);

      // WAIT_STATES=3
      start(1, 32'h00, 0, 32'h0, 4'h0, 0, "ws3_rd00");            complete(1, 1);
      start(1, 32'h1C, 1, 32'h0F0F_A5A5, 4'b1100, 0, "ws3_wr1c"); complete(1, 1);
      start(1, 32'h1C, 0, 32'h0, 4'h0, 0, "ws3_rd1c");            complete(1, 1);
      chk_regs(1, "ws3_regs");

      // psel dropped mid-ACCESS
      start(1, 32'h0C, 1, 32'h1357_9BDF, 4'hF, 1, "drop_wr");
      @(posedge pclk); #1;
      @(negedge pclk);
      check("drop_rdy_a", 32'(pready3), 32'd0);
      @(posedge pclk); #1;
      psel3 = 1'b0; penable = 1'b0;
      @(negedge pclk);
      check("drop_rdy_b", 32'(pready3), 32'd0);
      @(posedge pclk); #1;
      chk_regs(1, "after_drop");
      start(1, 32'h0C, 1, 32'h2468_ACE0, 4'hF, 0, "post_drop_wr"); complete(1, 1);
      start(1, 32'h0C, 0, 32'h0, 4'h0, 0, "post_drop_rd");         complete(1, 1);
      chk_regs(1, "final3");
      chk_regs(0, "final0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
